// File: rtl/alarm_controller_if.sv
// Bundle between the BCD time counters / user panel and the alarm controller.
// The master drives the time digits, ticks and buttons. The slave drives the alarm digits, state and buzzer.
interface alarm_controller_if;
    logic [1:0] hour_t;
    logic [3:0] hour_u;
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic       sec_tick;
    logic       min_tick;
    logic       alarm_on;
    logic       set_en;
    logic       btn_hour;
    logic       btn_min;
    logic       snooze;
    logic       stop;
    logic [1:0] al_hour_t;
    logic [3:0] al_hour_u;
    logic [2:0] al_min_t;
    logic [3:0] al_min_u;
    logic [1:0] state;
    logic       buzz;

    modport master (
        output hour_t, hour_u, min_t, min_u, sec_tick, min_tick,
               alarm_on, set_en, btn_hour, btn_min, snooze, stop,
        input  al_hour_t, al_hour_u, al_min_t, al_min_u, state, buzz
    );

    modport slave (
        input  hour_t, hour_u, min_t, min_u, sec_tick, min_tick,
               alarm_on, set_en, btn_hour, btn_min, snooze, stop,
        output al_hour_t, al_hour_u, al_min_t, al_min_u, state, buzz
    );
endinterface

// File: rtl/alarm_controller.sv
// Alarm controller: holds the BCD alarm time and runs the ring/snooze/stop FSM, with a 1 s cadence buzzer.
// Latency: every output is registered, so each responds one cycle after the input that causes it.
// Backpressure: none. Levels and pulses are sampled every cycle.
module alarm_controller #(
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic               clk,
    input  logic               rst,
    alarm_controller_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RINGING = 2'd2, SNOOZE = 2'd3} state_t;

    localparam logic [7:0] SNZ_LEN  = 8'(SNOOZE_MIN);
    localparam logic [7:0] RING_MAX = 8'(RING_TIMEOUT_MIN);
    localparam logic [3:0] SNZ_MAX  = 4'(MAX_SNOOZE);

    state_t     state_q, state_d;
    logic       buzz_q, buzz_d;
    logic       match_q, match_d;
    logic [1:0] al_hour_t_q, al_hour_t_d;
    logic [3:0] al_hour_u_q, al_hour_u_d;
    logic [2:0] al_min_t_q, al_min_t_d;
    logic [3:0] al_min_u_q, al_min_u_d;
    logic [3:0] snooze_cnt_q, snooze_cnt_d;
    logic [7:0] timeout_cnt_q, timeout_cnt_d;
    logic [7:0] snz_timer_q, snz_timer_d;
    logic       set_ok;
    logic       trigger;

    // Alarm time entry is only accepted while the alarm is not in an active ring cycle.
    assign set_ok = bus.set_en && (state_q == IDLE || state_q == ARMED);

    always_comb begin
        al_hour_t_d = al_hour_t_q;
        al_hour_u_d = al_hour_u_q;
        al_min_t_d  = al_min_t_q;
        al_min_u_d  = al_min_u_q;
        if (set_ok && bus.btn_hour) begin
            if (al_hour_t_q == 2'd2 && al_hour_u_q == 4'd3) begin
                al_hour_t_d = 2'd0;
                al_hour_u_d = 4'd0;
            end else if (al_hour_u_q == 4'd9) begin
                al_hour_t_d = al_hour_t_q + 2'd1;
                al_hour_u_d = 4'd0;
            end else begin
                al_hour_u_d = al_hour_u_q + 4'd1;
            end
        end
        if (set_ok && bus.btn_min) begin
            if (al_min_u_q == 4'd9) begin
                al_min_u_d = 4'd0;
                al_min_t_d = (al_min_t_q == 3'd5) ? 3'd0 : al_min_t_q + 3'd1;
            end else begin
                al_min_u_d = al_min_u_q + 4'd1;
            end
        end
    end

    assign match_d = (bus.hour_t == al_hour_t_q) && (bus.hour_u == al_hour_u_q) &&
                     (bus.min_t == al_min_t_q) && (bus.min_u == al_min_u_q);
    assign trigger = match_d && !match_q && !bus.set_en;

    always_comb begin
        state_d       = state_q;
        buzz_d        = buzz_q;
        snooze_cnt_d  = snooze_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        snz_timer_d   = snz_timer_q;
        if (!bus.alarm_on) begin
            state_d       = IDLE;
            buzz_d        = 1'b0;
            snooze_cnt_d  = 4'd0;
            timeout_cnt_d = 8'd0;
            snz_timer_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                    buzz_d  = 1'b0;
                end
                ARMED: begin
                    buzz_d = 1'b0;
                    if (trigger) begin
                        state_d       = RINGING;
                        snooze_cnt_d  = 4'd0;
                        timeout_cnt_d = 8'd0;
                        buzz_d        = 1'b1;
                    end
                end
                RINGING: begin
                    if (bus.stop) begin
                        state_d = ARMED;
                        buzz_d  = 1'b0;
                    end else if (bus.snooze && snooze_cnt_q < SNZ_MAX) begin
                        state_d      = SNOOZE;
                        buzz_d       = 1'b0;
                        snooze_cnt_d = snooze_cnt_q + 4'd1;
                        snz_timer_d  = SNZ_LEN;
                    end else begin
                        if (bus.sec_tick)
                            buzz_d = !buzz_q;
                        if (bus.min_tick && timeout_cnt_q < RING_MAX) begin
                            timeout_cnt_d = timeout_cnt_q + 8'd1;
                            if (timeout_cnt_q + 8'd1 == RING_MAX) begin
                                state_d = ARMED;
                                buzz_d  = 1'b0;
                            end
                        end
                    end
                end
                SNOOZE: begin
                    buzz_d = 1'b0;
                    if (bus.stop) begin
                        state_d = ARMED;
                    end else if (bus.min_tick && snz_timer_q != 8'd0) begin
                        snz_timer_d = snz_timer_q - 8'd1;
                        if (snz_timer_q == 8'd1) begin
                            state_d       = RINGING;
                            timeout_cnt_d = 8'd0;
                            buzz_d        = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // match_q resets high so a clock sitting on the alarm time at power-up does not ring.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            buzz_q        <= 1'b0;
            match_q       <= 1'b1;
            al_hour_t_q   <= 2'd0;
            al_hour_u_q   <= 4'd0;
            al_min_t_q    <= 3'd0;
            al_min_u_q    <= 4'd0;
            snooze_cnt_q  <= 4'd0;
            timeout_cnt_q <= 8'd0;
            snz_timer_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            buzz_q        <= buzz_d;
            match_q       <= match_d;
            al_hour_t_q   <= al_hour_t_d;
            al_hour_u_q   <= al_hour_u_d;
            al_min_t_q    <= al_min_t_d;
            al_min_u_q    <= al_min_u_d;
            snooze_cnt_q  <= snooze_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            snz_timer_q   <= snz_timer_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.buzz      = buzz_q;
    assign bus.al_hour_t = al_hour_t_q;
    assign bus.al_hour_u = al_hour_u_q;
    assign bus.al_min_t  = al_min_t_q;
    assign bus.al_min_u  = al_min_u_q;
endmodule

// File: doc/alarm_controller.md
# alarm_controller

Alarm controller for the alarm clock datapath. It sits directly downstream of the BCD time counters and consumes their hour and minute digits plus the second and minute carry pulses. It holds the user-set alarm time in BCD and runs the ring/snooze/stop state machine. It drives a buzzer enable that beeps at a 1 s on / 1 s off cadence.

## Interface
Parameters:
- SNOOZE_MIN, 5: snooze length in minute ticks; legal range 1..255.
- RING_TIMEOUT_MIN, 10: minute ticks of unattended ringing before auto-stop; legal range 1..255.
- MAX_SNOOZE, 3: snoozes allowed per alarm event; legal range 1..15.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- hour_t, input, 2: current hour tens digit, BCD.
- hour_u, input, 4: current hour units digit, BCD.
- min_t, input, 3: current minute tens digit, BCD.
- min_u, input, 4: current minute units digit, BCD.
- sec_tick, input, 1: one-cycle pulse per second.
- min_tick, input, 1: one-cycle pulse per minute.
- alarm_on, input, 1: level; alarm enabled switch.
- set_en, input, 1: level; alarm-set mode.
- btn_hour, input, 1: one-cycle pulse, pre-debounced; increments the alarm hour.
- btn_min, input, 1: one-cycle pulse, pre-debounced; increments the alarm minute.
- snooze, input, 1: one-cycle pulse.
- stop, input, 1: one-cycle pulse.
- al_hour_t, output, 2: alarm hour tens digit.
- al_hour_u, output, 4: alarm hour units digit.
- al_min_t, output, 3: alarm minute tens digit.
- al_min_u, output, 4: alarm minute units digit.
- state, output, 2: current state; IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
- buzz, output, 1: buzzer enable; registered.

## Operation
- Alarm time register:
  - Reset value is 00:00.
  - btn_hour and btn_min act only when set_en=1 and state is IDLE or ARMED; they are ignored in RINGING and SNOOZE.
  - Hour increments in BCD: units 9 -> 0 with tens+1; 23 -> 00.
  - Minute increments in BCD: 59 -> 00, with no carry into the hour.
  - btn_hour and btn_min in the same cycle update both fields.
- Match:
  - match = (current HH:MM == alarm HH:MM).
  - match_q is the registered match; its reset value is 1, so there is no spurious ring at power-up.
  - trigger = match & ~match_q & ~set_en. The alarm fires once per entry into the matching minute, never while set_en is high.
- State machine, highest priority first:
  - alarm_on=0: any state -> IDLE. The snooze and timeout counters are cleared.
  - IDLE -> ARMED when alarm_on=1.
  - ARMED -> RINGING on trigger. snooze_cnt is cleared, timeout_cnt is cleared, and buzz is set to 1.
  - RINGING:
    - stop -> ARMED.
    - Otherwise snooze with snooze_cnt < MAX_SNOOZE -> SNOOZE. snooze_cnt is incremented and snz_timer is loaded with SNOOZE_MIN.
    - Otherwise, on min_tick, timeout_cnt is incremented. When it reaches RING_TIMEOUT_MIN the FSM returns to ARMED.
    - A snooze pulse with snooze_cnt == MAX_SNOOZE is ignored, and ringing continues.
  - SNOOZE:
    - stop -> ARMED.
    - Otherwise min_tick decrements snz_timer. When the decrement reaches 0 the FSM goes to RINGING, timeout_cnt is cleared and buzz is set to 1.
    - trigger is ignored.
- buzz:
  - 0 in all states except RINGING.
  - In RINGING it toggles on each sec_tick.
  - It is forced to 1 on the cycle of entry into RINGING.
- Counters are 8-bit unsigned; snooze_cnt is 4-bit. No counter wraps: each saturates at its target.

## Timing
- Reset values: state=IDLE, buzz=0, alarm=00:00, match_q=1, all counters 0.
- All outputs are registered.
- Latency:
  - Input change -> state/buzz update: 1 cycle.
  - trigger at edge k -> state=RINGING and buzz=1 after edge k.
  - Button pulse -> al_* updated the next cycle.
- Simultaneous events:
  - stop with snooze: stop wins.
  - snooze with min_tick in RINGING: snooze wins, and timeout_cnt is not incremented.
  - stop on the cycle snz_timer would expire: stop wins, and the FSM goes to ARMED.
  - sec_tick on the cycle RINGING is entered: buzz=1, no toggle.
- Reset mid-ring: buzz drops to 0 asynchronously, and the alarm time returns to 00:00.
- Time digits are sampled every cycle. The upstream counters may update the digits and pulse min_tick in the same cycle; match is evaluated on the new digits.

## Test plan
- Reset, alarm_on=1, time 00:00 -> state goes to ARMED; no RINGING because match_q=1; buzz=0.
- set_en=1, 20 btn_hour pulses then 65 btn_min pulses -> alarm reads 20:05. Then 4 more btn_hour pulses -> 00:05.
- Alarm 07:30, time steps 07:29 -> 07:30 -> RINGING one cycle later, buzz=1, buzz toggles on each sec_tick. With RING_TIMEOUT_MIN=10, the 10th min_tick returns the FSM to ARMED with buzz=0. No re-trigger while time stays 07:30.
- RINGING, snooze -> SNOOZE. 5 min_ticks -> RINGING on the 5th. Repeat 3 snoozes; the 4th snooze pulse is ignored and the FSM stays RINGING.
- RINGING with stop and snooze in the same cycle -> ARMED. In SNOOZE, stop on the expiry min_tick -> ARMED.
- alarm_on dropped during SNOOZE -> IDLE next cycle, buzz=0. Assert rst during RINGING -> immediate IDLE, buzz=0, alarm 00:00.
